exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC0_0380, redirect target for exceptions and interrupts.
REQ-002 Parameter DRAIN_MAX, default 16, maximum DRAIN cycles before forced commit (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 commit_valid  input  1  valid instruction occupies the MEM/commit slot this cycle.
REQ-006 exc_valid  input  1  that instruction raised a synchronous exception.
REQ-007 exc_code  input  5  ExcCode of that exception.
REQ-008 exc_pc  input  32  PC of the commit-slot instruction.
REQ-009 exc_badaddr / exc_isbad / exc_bd  input  32/1/1  bad virtual address, address-fault flag, delay-slot flag.
REQ-010 eret_valid  input  1  commit-slot instruction is ERET.
REQ-011 int_pending  input  1  CP0 interrupt output (already masked by IE/EXL/IM).
REQ-012 cp0_epc  input  32  current CP0 EPC.
REQ-013 mem_busy  input  1  outstanding data-memory transaction.
REQ-014 redirect_ready  input  1  fetch stage accepts the redirect.
REQ-015 stall  output  1  freeze all pipeline stages.
REQ-016 flush  output  1  kill all in-flight instructions.
REQ-017 cp0_exception / cp0_eret  output  1/1  single-cycle CP0 commit strobes.
REQ-018 cp0_code / cp0_pc / cp0_badaddr / cp0_isbad / cp0_bd  output  5/32/32/1/1  captured event fields for CP0.
REQ-019 redirect_valid / redirect_pc  output  1/32  fetch redirect request and target.
REQ-020 drain_timeout  output  1  sticky flag: a DRAIN ended via DRAIN_MAX.

Function
REQ-021 FSM states: IDLE, DRAIN, COMMIT, REDIRECT; encoding is free.
REQ-022 An event is accepted only in IDLE and only when commit_valid=1; requests in any other state or with commit_valid=0 are ignored.
REQ-023 Priority at acceptance: int_pending > exc_valid > eret_valid; exactly one event is captured.
REQ-024 Interrupt capture: code 5'd0, pc=exc_pc, isbad=0, bd=exc_bd; the commit-slot instruction is not executed.
REQ-025 Exception capture: code=exc_code, pc=exc_pc, badaddr=exc_badaddr, isbad=exc_isbad, bd=exc_bd.
REQ-026 ERET capture: record type only; no exception fields change.
REQ-027 On acceptance: IDLE -> DRAIN next cycle; the drain counter loads 0; stall asserts combinationally in the acceptance cycle and stays high through REDIRECT.
REQ-028 DRAIN: counter increments each cycle while mem_busy=1; exit to COMMIT when mem_busy=0 or counter reaches DRAIN_MAX-1; a forced exit sets drain_timeout.
REQ-029 DRAIN with mem_busy=0 on entry lasts exactly one cycle.
REQ-030 COMMIT (exactly one cycle): cp0_exception=1 for exception/interrupt, or cp0_eret=1 for ERET; flush=1; redirect_pc is latched from EXC_VECTOR, or from cp0_epc sampled this cycle.
REQ-031 REDIRECT: redirect_valid=1 and flush=1 held until redirect_ready=1; the transfer cycle returns to IDLE; redirect_pc is stable while redirect_valid=1.
REQ-032 Latency: acceptance to cp0 strobe is 2 cycles with mem_busy=0; acceptance to first redirect_valid is 3 cycles.
REQ-033 cp0_code/pc/badaddr/isbad/bd hold captured values from DRAIN until the next acceptance; they are meaningful only with cp0_exception.
REQ-034 cp0_exception and cp0_eret are never high together and never high outside COMMIT.
REQ-035 Back-to-back: a new event may be accepted in the IDLE cycle following the REDIRECT handshake.
REQ-036 drain_timeout stays set until reset.

Reset
REQ-037 Asynchronous reset in any state forces IDLE and discards the captured event.
REQ-038 During reset all outputs are 0, including drain_timeout and redirect_pc, and the drain counter is 0.
REQ-039 The first acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-040 exc_valid=1, exc_code=5'h04, exc_pc=32'h8000_0010, badaddr=32'h0000_0003, mem_busy=0, redirect_ready=1 -> cp0_exception 2 cycles later with code 4, isbad=1; redirect_pc=32'hBFC0_0380; back in IDLE after 4 cycles.
REQ-041 int_pending=1 and exc_valid=1 in the same cycle -> cp0_code=0, cp0_pc=exc_pc; exception fields are ignored.
REQ-042 eret_valid=1, cp0_epc=32'h8000_1000 -> cp0_eret pulses once; cp0_exception=0; redirect_pc=32'h8000_1000.
REQ-043 mem_busy held 1 for 40 cycles, DRAIN_MAX=16 -> COMMIT after 16 DRAIN cycles; drain_timeout=1 and stays 1.
REQ-044 redirect_ready=0 for 5 cycles -> redirect_valid, flush, stall, and redirect_pc are held constant for 5 cycles, then the transfer occurs and the FSM returns to IDLE.
REQ-045 reset asserted mid-DRAIN -> all outputs 0 immediately; a new exception after deassertion completes normally.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: precise exception/interrupt/ERET sequencer (IDLE -> DRAIN -> COMMIT -> REDIRECT).
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          DRAIN_MAX  = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        commit_valid_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_badaddr_i,
  input  logic        exc_isbad_i,
  input  logic        exc_bd_i,
  input  logic        eret_valid_i,
  input  logic        int_pending_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        mem_busy_i,
  input  logic        redirect_ready_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        cp0_exception_o,
  output logic        cp0_eret_o,
  output logic [4:0]  cp0_code_o,
  output logic [31:0] cp0_pc_o,
  output logic [31:0] cp0_badaddr_o,
  output logic        cp0_isbad_o,
  output logic        cp0_bd_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        drain_timeout_o
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  localparam logic [7:0] CNT_LAST = 8'(DRAIN_MAX - 1);
  state_t     state_q;
  logic [7:0] cnt_q;
  logic       eret_q;
  logic       accept, drain_done;
  assign accept = !reset_i && state_q == IDLE && commit_valid_i &&
                  (int_pending_i || exc_valid_i || eret_valid_i);
  assign drain_done = !mem_busy_i || cnt_q == CNT_LAST;
  // stall must rise in the acceptance cycle itself, before the state changes
  assign stall_o = accept || state_q != IDLE;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      eret_q           <= 1'b0;
      flush_o          <= 1'b0;
      cp0_exception_o  <= 1'b0;
      cp0_eret_o       <= 1'b0;
      cp0_code_o       <= '0;
      cp0_pc_o         <= '0;
      cp0_badaddr_o    <= '0;
      cp0_isbad_o      <= 1'b0;
      cp0_bd_o         <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      drain_timeout_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= DRAIN;
          cnt_q   <= '0;
          eret_q  <= !(int_pending_i || exc_valid_i);
          if (int_pending_i) begin
            cp0_code_o  <= 5'd0;
            cp0_pc_o    <= exc_pc_i;
            cp0_isbad_o <= 1'b0;
            cp0_bd_o    <= exc_bd_i;
          end else if (exc_valid_i) begin
            cp0_code_o    <= exc_code_i;
            cp0_pc_o      <= exc_pc_i;
            cp0_badaddr_o <= exc_badaddr_i;
            cp0_isbad_o   <= exc_isbad_i;
            cp0_bd_o      <= exc_bd_i;
          end
        end
        DRAIN: begin
          if (mem_busy_i) cnt_q <= cnt_q + 8'd1;
          if (drain_done) begin
            state_q         <= COMMIT;
            cp0_exception_o <= !eret_q;
            cp0_eret_o      <= eret_q;
            flush_o         <= 1'b1;
            if (mem_busy_i) drain_timeout_o <= 1'b1;
          end
        end
        COMMIT: begin
          state_q          <= REDIRECT;
          cp0_exception_o  <= 1'b0;
          cp0_eret_o       <= 1'b0;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= eret_q ? cp0_epc_i : EXC_VECTOR;
        end
        REDIRECT: if (redirect_ready_i) begin
          state_q          <= IDLE;
          redirect_valid_o <= 1'b0;
          flush_o          <= 1'b0;
        end
      endcase
    end
  end
endmodule
